bcd2bin_seq: RTL and testbench
==============================

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 The module SHALL have parameter W, default 8, meaning the binary output width in bits (W >= 4).
REQ-002 The module SHALL have derived localparam BW = W + (W-4)/3 + 1, the BCD input width (10 for W=8).
REQ-003 The module SHALL have derived localparam ND = ceil(BW/4), the BCD digit count; the internal BCD register is 4*ND bits, zero-padded at the top.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: request to convert; sampled only in IDLE.
REQ-007 Port bcd, input, BW bits: packed BCD operand, digit 0 in bits [3:0]; sampled on the accepting edge only.
REQ-008 Port busy, output, 1 bit: high in SHIFT and DONE states.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking valid bin/err.
REQ-010 Port bin, output, W bits: converted binary result.
REQ-011 Port err, output, 1 bit: result invalid (bad digit or overflow).

Function
REQ-012 The module SHALL use the states IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 SHALL, on that edge:
- load the zero-padded bcd into the BCD register B;
- clear the result register R (W bits);
- clear the shift counter;
- go to SHIFT, unless the digit check fails.
REQ-014 Digit check: if any bcd digit exceeds 9 at acceptance, the module SHALL go directly to DONE with bin=0 and err=1 (latency 1 edge).
REQ-015 Each SHIFT cycle SHALL do the following in one edge:
- shift the concatenation {B,R} right by 1 (B LSB enters R MSB);
- then subtract 3 from every 4-bit digit of the shifted B whose value is >= 8.
REQ-016 After exactly W SHIFT cycles, the module SHALL go to DONE.
- Outputs loaded on that edge: bin=R and err=0 if B==0.
- Otherwise (overflow, value > 2^W-1): bin=0 and err=1.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 Latency from the start-accepting edge to done high: W+1 edges for valid input (9 for W=8).
REQ-019 start SHALL be ignored while busy=1; bcd changes after acceptance SHALL NOT affect the result.
REQ-020 bin and err SHALL hold their values from the last DONE until the next DONE.
REQ-021 done SHALL NOT be asserted in any state other than DONE.
REQ-022 start held high continuously SHALL cause back-to-back conversions, one accepted per return to IDLE; the IDLE cycle is mandatory.
REQ-023 Arithmetic: digit correction SHALL be 4-bit unsigned per digit with no inter-digit borrow; the counter SHALL be wide enough to hold W.

Reset
REQ-024 reset=1 SHALL asynchronously force:
- state to IDLE;
- B, R and the counter to 0;
- busy=0, done=0, bin=0, err=0.
REQ-025 reset asserted mid-conversion SHALL abort it with no done pulse; the first start after release SHALL convert normally.

Verification
REQ-026 W=8: bcd=10'h255, start pulse -> done 9 edges later, bin=8'hFF, err=0; busy high for the 9 cycles ending with done.
REQ-027 W=8: bcd=10'h000 -> bin=8'h00, err=0; bcd=10'h128 -> bin=8'h80, err=0.
REQ-028 W=8: bcd=10'h256 (overflow) -> done after 9 edges, bin=0, err=1; bcd=10'h0A5 (bad digit) -> done on the next edge, bin=0, err=1.
REQ-029 Start bcd=10'h099, then raise start with bcd=10'h200 during SHIFT -> a single done with bin=8'h63; the second request is ignored.
REQ-030 Assert reset 4 edges into a conversion -> all outputs 0 immediately, no done; after release, bcd=10'h042 -> bin=8'h2A, err=0.
REQ-031 start held high with bcd=10'h017 -> a done every 10 cycles, each with bin=8'h11.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble: W shift/correct
// steps, then the result is checked for leftover BCD (overflow).
module bcd2bin_digit (
  input  logic [3:0] sh_i,
  input  logic [3:0] raw_i,
  output logic [3:0] fix_o,
  output logic       bad_o
);
  assign fix_o = (sh_i >= 4'd8) ? sh_i - 4'd3 : sh_i;
  assign bad_o = (raw_i > 4'd9);
endmodule

module bcd2bin_seq #(
  parameter  int W  = 8,
  localparam int BW = W + (W-4)/3 + 1,
  localparam int ND = (BW + 3) / 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [BW-1:0] bcd,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  bin,
  output logic          err
);
  localparam int CW = $clog2(W+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q;
  logic [4*ND-1:0] b_q, b_d, b_sh, bcd_pad;
  logic [W-1:0]    r_q, r_d, bin_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q, err_q;
  logic [ND-1:0]   bad;

  assign bcd_pad     = (4*ND)'(bcd);
  assign {b_sh, r_d} = {b_q, r_q} >> 1;

  // Each digit is corrected independently after the shift; the same lane also
  // flags an out-of-range digit on the incoming operand.
  for (genvar g = 0; g < ND; g++) begin : g_dig
    bcd2bin_digit u_dig (
      .sh_i  (b_sh[4*g +: 4]),
      .raw_i (bcd_pad[4*g +: 4]),
      .fix_o (b_d[4*g +: 4]),
      .bad_o (bad[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            b_q    <= bcd_pad;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (|bad) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              bin_q   <= '0;
              err_q   <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          b_q   <= b_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W-1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            // Anything left in B means the value did not fit in W bits.
            if (b_d == '0) begin
              bin_q <= r_d;
              err_q <= 1'b0;
            end else begin
              bin_q <= '0;
              err_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bin  = bin_q;
  assign err  = err_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scenario bench for bcd2bin_seq: expected results queued on stimulus and
// compared when done pulses.
module tb_bcd2bin_seq;
  localparam int W  = 8;
  localparam int BW = 10;

  typedef struct packed {
    logic [W-1:0] bin;
    logic         err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [BW-1:0] bcd;
  logic          busy, done, err;
  logic [W-1:0]  bin;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  bcd2bin_seq #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input logic [W-1:0] b, input logic e);
    exp_t x;
    x.bin = b;
    x.err = e;
    sb.push_back(x);
  endtask

  // Called just after the accepting edge; lat counts edges including that one.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 1;
    busy_cyc = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (done === 1'b1 && busy === 1'b1) busy_cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bcd = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, bin, err} !== '0)
      $display("FAIL reset_state: got busy=%b done=%b bin=%h err=%b, want all 0", busy, done, bin, err);
    if ({busy, done, bin, err} !== '0) errors++;
    reset = 1'b0;
  endtask

  task automatic test_convert(input logic [BW-1:0] v, input logic [W-1:0] eb,
                              input logic e, input int elat, input string name);
    int   lat, bc;
    exp_t x;
    push_exp(eb, e);
    @(posedge clk); #1;
    start = 1'b1; bcd = v;
    @(posedge clk); #1;
    start = 1'b0; bcd = BW'($urandom);
    wait_done(lat, bc);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: no done after %0d edges", name, lat);
      void'(sb.pop_front());
      return;
    end
    x = sb.pop_front();
    checks++;
    if (lat != elat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges, want %0d", name, lat, elat);
    end
    checks++;
    if (bin !== x.bin || err !== x.err) begin
      errors++;
      $display("FAIL %s_result: got bin=%h err=%b, want bin=%h err=%b", name, bin, err, x.bin, x.err);
    end
    checks++;
    if (bc != elat) begin
      errors++;
      $display("FAIL %s_busy: busy high %0d cycles, want %0d", name, bc, elat);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || bin !== x.bin || err !== x.err) begin
      errors++;
      $display("FAIL %s_hold: got done=%b bin=%h err=%b, want done=0 bin=%h err=%b", name, done, bin, err, x.bin, x.err);
    end
  endtask

  task automatic test_ignore_start();
    int   lat, extra;
    exp_t x;
    push_exp(8'h63, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; bcd = 10'h099;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 3) begin start = 1'b1; bcd = 10'h200; end
      if (lat == 5) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_timeout: no done after %0d edges", lat);
      void'(sb.pop_front());
      return;
    end
    x = sb.pop_front();
    checks++;
    if (bin !== x.bin || err !== x.err || lat != 9) begin
      errors++;
      $display("FAIL ignore_result: got bin=%h err=%b lat=%0d, want bin=%h err=%b lat=9", bin, err, lat, x.bin, x.err);
    end
    extra = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_second: saw %0d busy/done cycles after first result, want 0", extra);
    end
  endtask

  task automatic test_abort();
    int seen;
    @(posedge clk); #1;
    start = 1'b1; bcd = 10'h255;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, bin, err} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b bin=%h err=%b, want all 0", busy, done, bin, err);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen++;
    end
    reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_nodone: saw done %0d times, want 0", seen);
    end
    test_convert(10'h042, 8'h2A, 1'b0, 9, "after_abort");
  endtask

  task automatic test_back_to_back();
    int   t_prev, wait_n;
    exp_t x;
    for (int k = 0; k < 3; k++) push_exp(8'h11, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; bcd = 10'h017;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_n = 0;
      @(posedge clk); #1;
      while (done !== 1'b1 && wait_n < 40) begin
        @(posedge clk); #1;
        wait_n++;
      end
      if (k == 2) start = 1'b0;
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL b2b_timeout: done %0d never seen", k);
        return;
      end
      x = sb.pop_front();
      checks++;
      if (bin !== x.bin || err !== x.err) begin
        errors++;
        $display("FAIL b2b_result: done %0d got bin=%h err=%b, want bin=%h err=%b", k, bin, err, x.bin, x.err);
      end
      if (k > 0) begin
        checks++;
        if (cyc - t_prev != 10) begin
          errors++;
          $display("FAIL b2b_period: done %0d after %0d cycles, want 10", k, cyc - t_prev);
        end
      end
      t_prev = cyc;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_convert(10'h255, 8'hFF, 1'b0, 9, "max");
    test_convert(10'h000, 8'h00, 1'b0, 9, "zero");
    test_convert(10'h128, 8'h80, 1'b0, 9, "msb");
    test_convert(10'h256, 8'h00, 1'b1, 9, "overflow");
    test_convert(10'h0A5, 8'h00, 1'b1, 1, "bad_digit");
    test_ignore_start();
    test_abort();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
